play_source_arbiter: RTL and testbench



---
 rtl/play_source_arbiter_pkg.sv | 23 ++
 rtl/play_source_arbiter_timer.sv | 29 ++
 rtl/play_source_arbiter.sv | 139 +++++++++++++
 tb/tb_play_source_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/play_source_arbiter_pkg.sv
// rtl/play_source_arbiter_pkg.sv - shared types and constants for the playback source arbiter
package play_source_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN1 = 2'd1,
        ST_OWN2 = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    localparam int CW_DEF = 3;
    localparam int VW_DEF = 16;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC1     = 2'd1;
    localparam logic [1:0] SRC2     = 2'd2;

    // The source that is not s (SRC_NONE maps to SRC1, never used that way)
    function automatic logic [1:0] other_src(input logic [1:0] s);
        return (s == SRC1) ? SRC2 : SRC1;
    endfunction

endpackage

// File: rtl/play_source_arbiter_timer.sv
// rtl/play_source_arbiter_timer.sv - clearable saturating cycle counter with done flag
module arb_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_done
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] r_cnt;

    assign o_done = (r_cnt == LAST);

    // Held at zero while cleared, otherwise counts up and sticks at LIMIT-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (!o_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/play_source_arbiter.sv
// rtl/play_source_arbiter.sv - two-source playback arbiter with hold time and muted handover gap
module play_source_arbiter
    import play_source_arbiter_pkg::*;
#(
    parameter int CW       = CW_DEF,
    parameter int VW       = VW_DEF,
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req1,
    input  logic [CW-1:0] current1,
    input  logic [VW-1:0] volume1,
    input  logic          req2,
    input  logic [CW-1:0] current2,
    input  logic [VW-1:0] volume2,
    output logic          gnt1,
    output logic          gnt2,
    output logic          ena,
    output logic [CW-1:0] current,
    output logic [VW-1:0] volume,
    output logic          muted
);

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic [1:0]    r_last;
    logic [1:0]    r_target;
    logic          r_ena;
    logic [CW-1:0] r_current;
    logic [VW-1:0] r_volume;
    logic          r_muted;

    logic w_in_own;
    logic w_in_gap;
    logic w_hold_done;
    logic w_gap_done;
    logic w_tgt_req;
    logic w_oth_req;

    assign w_in_own  = (r_state == ST_OWN1) || (r_state == ST_OWN2);
    assign w_in_gap  = (r_state == ST_GAP);
    assign w_tgt_req = (r_target == SRC1) ? req1 : req2;
    assign w_oth_req = (other_src(r_target) == SRC1) ? req1 : req2;

    // Hold timer restarts on every entry into an OWN state (OWN is only entered from IDLE or GAP)
    arb_timer #(.LIMIT(HOLD_CYC)) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (!w_in_own),
        .o_done  (w_hold_done)
    );

    // Gap timer restarts on every entry into GAP
    arb_timer #(.LIMIT(GAP_CYC)) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (!w_in_gap),
        .o_done  (w_gap_done)
    );

    // Next-state decision; source 1 may preempt a settled source 2 owner, never the reverse
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req1 && req2)  w_next = (r_last == SRC1) ? ST_OWN2 : ST_OWN1;
                else if (req1)     w_next = ST_OWN1;
                else if (req2)     w_next = ST_OWN2;
            end
            ST_OWN1: begin
                if (w_hold_done && !req1) w_next = req2 ? ST_GAP : ST_IDLE;
            end
            ST_OWN2: begin
                if (w_hold_done && req1)       w_next = ST_GAP;
                else if (w_hold_done && !req2) w_next = ST_IDLE;
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    if (w_tgt_req)      w_next = (r_target == SRC1) ? ST_OWN1 : ST_OWN2;
                    else if (w_oth_req) w_next = (r_target == SRC1) ? ST_OWN2 : ST_OWN1;
                    else                w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, entry-side bookkeeping (last owner, gap target, selector) and registered datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_last    <= SRC2;
            r_target  <= SRC_NONE;
            r_ena     <= 1'b0;
            r_current <= '0;
            r_volume  <= '0;
            r_muted   <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_next == ST_OWN1 && r_state != ST_OWN1) begin
                r_last <= SRC1;
                r_ena  <= 1'b1;
            end
            if (w_next == ST_OWN2 && r_state != ST_OWN2) begin
                r_last <= SRC2;
                r_ena  <= 1'b0;
            end
            if (w_next == ST_GAP && r_state != ST_GAP) begin
                r_target <= (r_state == ST_OWN1) ? SRC2 : SRC1;
            end
            case (r_state)
                ST_OWN1: begin
                    r_current <= current1;
                    r_volume  <= volume1;
                    r_muted   <= 1'b0;
                end
                ST_OWN2: begin
                    r_current <= current2;
                    r_volume  <= volume2;
                    r_muted   <= 1'b0;
                end
                default: begin
                    r_volume <= '0;
                    r_muted  <= 1'b1;
                end
            endcase
        end
    end

    assign gnt1    = (r_state == ST_OWN1);
    assign gnt2    = (r_state == ST_OWN2);
    assign ena     = r_ena;
    assign current = r_current;
    assign volume  = r_volume;
    assign muted   = r_muted;

endmodule

// File: tb/tb_play_source_arbiter.sv
// tb/tb_play_source_arbiter.sv - directed self-checking bench for play_source_arbiter
module tb_play_source_arbiter;

    localparam int CW = 3;
    localparam int VW = 16;

    logic          clk;
    logic          rst_n;
    logic          req1;
    logic [CW-1:0] current1;
    logic [VW-1:0] volume1;
    logic          req2;
    logic [CW-1:0] current2;
    logic [VW-1:0] volume2;
    logic          gnt1;
    logic          gnt2;
    logic          ena;
    logic [CW-1:0] current;
    logic [VW-1:0] volume;
    logic          muted;

    int n_checks = 0;
    int n_fails  = 0;

    play_source_arbiter #(
        .CW(CW), .VW(VW), .HOLD_CYC(16), .GAP_CYC(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req1     (req1),
        .current1 (current1),
        .volume1  (volume1),
        .req2     (req2),
        .current2 (current2),
        .volume2  (volume2),
        .gnt1     (gnt1),
        .gnt2     (gnt2),
        .ena      (ena),
        .current  (current),
        .volume   (volume),
        .muted    (muted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; sample point is 1 time unit after the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req1 = 1'b0; req2 = 1'b0;
        current1 = '0; volume1 = '0; current2 = '0; volume2 = '0;

        // ---- reset values
        do_reset();
        check("rst_gnt1", 32'(gnt1), 0);
        check("rst_gnt2", 32'(gnt2), 0);
        check("rst_ena", 32'(ena), 0);
        check("rst_current", 32'(current), 0);
        check("rst_volume", 32'(volume), 0);
        check("rst_muted", 32'(muted), 1);

        // ---- single request latency (cycle 0 drive)
        req1 = 1'b1; current1 = 3'd3; volume1 = 16'h1234;
        step(1);                                   // cycle 1
        check("t1_gnt1", 32'(gnt1), 1);
        check("t1_ena", 32'(ena), 1);
        check("t1_vol_c1", 32'(volume), 0);
        step(1);                                   // cycle 2
        check("t1_current", 32'(current), 3);
        check("t1_volume", 32'(volume), 32'h1234);
        check("t1_muted", 32'(muted), 0);
        req1 = 1'b0;
        step(20);
        check("t1_idle_gnt1", 32'(gnt1), 0);
        check("t1_idle_vol", 32'(volume), 0);
        check("t1_idle_muted", 32'(muted), 1);
        check("t1_idle_cur_hold", 32'(current), 3);
        check("t1_idle_ena_hold", 32'(ena), 1);

        // ---- simultaneous requests after reset: source 1 first
        do_reset();
        current1 = 3'd1; volume1 = 16'h1111;
        current2 = 3'd5; volume2 = 16'hBEEF;
        req1 = 1'b1; req2 = 1'b1;                  // cycle 0
        step(1);                                   // cycle 1
        check("t2_gnt1_first", 32'(gnt1), 1);
        check("t2_gnt2_first", 32'(gnt2), 0);
        step(19);                                  // cycle 20
        req1 = 1'b0;
        step(1);                                   // cycle 21: gap 0
        check("t2_gap_gnt1", 32'(gnt1), 0);
        check("t2_gap_gnt2", 32'(gnt2), 0);
        step(1);                                   // cycle 22: gap 1
        check("t2_gap_vol", 32'(volume), 0);
        check("t2_gap_muted", 32'(muted), 1);
        check("t2_gap_cur_hold", 32'(current), 1);
        step(2);                                   // cycle 24: gap 3
        check("t2_gap_end_gnt2", 32'(gnt2), 0);
        check("t2_gap_ena_hold", 32'(ena), 1);
        step(1);                                   // cycle 25: own2 cycle 0
        check("t2_gnt2", 32'(gnt2), 1);
        check("t2_ena", 32'(ena), 0);
        step(1);                                   // cycle 26
        check("t2_vol2", 32'(volume), 32'hBEEF);
        check("t2_cur2", 32'(current), 5);
        check("t2_muted", 32'(muted), 0);

        // ---- preemption of source 2 after hold time
        step(2);                                   // cycle 28: own2 cycle 3
        req1 = 1'b1;
        step(12);                                  // cycle 40: own2 cycle 15
        check("t3_gnt2_held", 32'(gnt2), 1);
        step(1);                                   // cycle 41: gap 0
        check("t3_gap_gnt2", 32'(gnt2), 0);
        check("t3_gap_gnt1", 32'(gnt1), 0);
        step(3);                                   // cycle 44: gap 3
        check("t3_gap_last_gnt1", 32'(gnt1), 0);
        step(1);                                   // cycle 45: own1 cycle 0
        check("t3_gnt1", 32'(gnt1), 1);
        check("t3_ena", 32'(ena), 1);

        // ---- short req1 drop before hold done is ignored
        step(5);                                   // cycle 50: own1 cycle 5
        req1 = 1'b0; volume1 = 16'h5555;
        step(2);                                   // cycle 52
        req1 = 1'b1;
        check("t4_gnt1_kept", 32'(gnt1), 1);
        check("t4_vol_track", 32'(volume), 32'h5555);
        step(15);                                  // cycle 67: own1 cycle 22
        check("t4_no_preempt_gnt1", 32'(gnt1), 1);
        check("t4_no_preempt_gnt2", 32'(gnt2), 0);

        // ---- gap toward source 1 whose request vanishes: fall through to source 2
        req1 = 1'b0;                               // C = cycle 67
        step(5);                                   // C+5: own2 cycle 0
        check("t5_own2", 32'(gnt2), 1);
        req1 = 1'b1;
        step(16);                                  // C+21: gap toward 1
        check("t5_gap_a", 32'(gnt2), 0);
        step(1);                                   // C+22
        req1 = 1'b0;
        step(2);                                   // C+24: gap 3
        check("t5_gap_ena_hold", 32'(ena), 0);
        step(1);                                   // C+25
        check("t5_fall_gnt2", 32'(gnt2), 1);
        check("t5_fall_gnt1", 32'(gnt1), 0);
        step(1);                                   // C+26
        req1 = 1'b1;
        step(15);                                  // C+41: gap toward 1
        check("t5_gap_b", 32'(gnt2), 0);
        step(1);                                   // C+42
        req1 = 1'b0; req2 = 1'b0;
        step(3);                                   // C+45: idle
        check("t5_idle_gnt1", 32'(gnt1), 0);
        check("t5_idle_gnt2", 32'(gnt2), 0);
        step(1);
        check("t5_idle_vol", 32'(volume), 0);
        check("t5_idle_muted", 32'(muted), 1);
        check("t5_idle_gnt2_stay", 32'(gnt2), 0);

        // ---- asynchronous reset during OWN2
        volume2 = 16'hA5A5;
        req2 = 1'b1;
        step(1);
        check("t6_gnt2", 32'(gnt2), 1);
        step(3);
        check("t6_vol2", 32'(volume), 32'hA5A5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_gnt2", 32'(gnt2), 0);
        check("t6_rst_vol", 32'(volume), 0);
        check("t6_rst_muted", 32'(muted), 1);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("t6_regrant_gnt2", 32'(gnt2), 1);
        check("t6_regrant_ena", 32'(ena), 0);
        step(1);
        check("t6_regrant_vol", 32'(volume), 32'hA5A5);
        check("t6_regrant_muted", 32'(muted), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
